// File: rtl/ifq_param.sv
// Instruction fetch queue: line-aligned I-cache requests into a DEPTH-line circular buffer, one instruction per cycle out.
// Define IFQ_BYPASS_EN to let a line returning into an empty queue be dispatched in its arrival cycle.
//
// state  | meaning
// S_IDLE | no cache request outstanding; request the next line when the queue has room
// S_WAIT | request accepted by the cache; waiting for the line to return
module ifq_param #(
    parameter int          WORDS_PER_LINE = 4,
    parameter int          DEPTH          = 4,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [32*WORDS_PER_LINE-1:0]  i_line,
    input  logic                          i_line_valid,
    input  logic                          i_rd_en,
    input  logic [31:0]                   i_jmp_addr,
    input  logic                          i_jmp_valid,
    output logic [31:0]                   o_fetch_pc,
    output logic                          o_fetch_req,
    output logic                          o_abort,
    output logic [31:0]                   o_pc,
    output logic [31:0]                   o_instr,
    output logic                          o_empty,
    output logic                          o_full
);
    localparam int          WO_W       = $clog2(WORDS_PER_LINE);
    localparam int          PTR_W      = $clog2(DEPTH);
    localparam int          OFF_W      = WO_W + 2;
    localparam logic [31:0] LINE_BYTES = 32'(4 * WORDS_PER_LINE);
    localparam logic [31:0] LINE_MASK  = ~(LINE_BYTES - 32'd1);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [WO_W-1:0] WO_LAST  = WO_W'(WORDS_PER_LINE - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                           state, state_nxt;
    logic [WORDS_PER_LINE-1:0][31:0]  mem [DEPTH];
    logic [WORDS_PER_LINE-1:0][31:0]  line_words;
    logic [PTR_W-1:0]                 wp, rp;
    logic [WO_W-1:0]                  wo;
    logic [PTR_W:0]                   cnt;
    logic [31:0]                      pc, fetch_pc;
    logic                             abort;
    logic                             fetch_req;
    logic                             line_in, bypass, empty;
    logic                             consume, last_word, pop, push;
    logic                             unused_addr_lsb;

    assign line_words      = i_line;
    assign unused_addr_lsb = ^i_jmp_addr[1:0];

    // A line arriving in the jump cycle belongs to the aborted request and is dropped.
    assign line_in = (state == S_WAIT) && i_line_valid && !i_jmp_valid;

`ifdef IFQ_BYPASS_EN
    assign bypass = line_in && (cnt == '0);
`else
    assign bypass = 1'b0;
`endif

    assign empty     = (cnt == '0) && !bypass;
    assign consume   = i_rd_en && !empty && !i_jmp_valid;
    assign last_word = (wo == WO_LAST);
    assign pop       = consume && last_word && !bypass;
    // A bypassed line whose last word is taken on arrival is never stored.
    assign push      = line_in && !(bypass && consume && last_word);

    always_comb begin
        state_nxt = state;
        fetch_req = 1'b0;
        case (state)
            S_IDLE: begin
                fetch_req = (cnt < CNT_FULL) && !i_jmp_valid && !i_rst;
                if (fetch_req) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_line_valid) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (i_jmp_valid) state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            wo       <= RESET_PC[OFF_W-1:2];
            pc       <= RESET_PC;
            fetch_pc <= RESET_PC & LINE_MASK;
            abort    <= 1'b0;
        end else if (i_jmp_valid) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            wo       <= i_jmp_addr[OFF_W-1:2];
            pc       <= {i_jmp_addr[31:2], 2'b00};
            fetch_pc <= i_jmp_addr & LINE_MASK;
            abort    <= (state == S_WAIT);
        end else begin
            abort <= 1'b0;
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            if (line_in) fetch_pc <= fetch_pc + LINE_BYTES;
            if (consume) begin
                pc <= pc + 32'd4;
                wo <= wo + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wp] <= line_words;
    end

    always_comb begin
        o_instr = 32'h0;
        if (bypass)      o_instr = line_words[wo];
        else if (!empty) o_instr = mem[rp][wo];
    end

    assign o_empty     = empty;
    assign o_full      = (cnt == CNT_FULL);
    assign o_pc        = pc;
    assign o_fetch_pc  = fetch_pc;
    assign o_fetch_req = fetch_req;
    assign o_abort     = abort;

endmodule

// File: tb/tb_ifq_param.sv
// Bench for ifq_param: directed literal scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_ifq_param;
    localparam int          W   = 4;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] LB  = 32'(4 * W);

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [32*W-1:0]   i_line = '0;
    logic              i_line_valid = 1'b0;
    logic              i_rd_en = 1'b0;
    logic [31:0]       i_jmp_addr = '0;
    logic              i_jmp_valid = 1'b0;
    logic [31:0]       o_fetch_pc, o_pc, o_instr;
    logic              o_fetch_req, o_abort, o_empty, o_full;

    always #5 clk = ~clk;

    ifq_param #(.WORDS_PER_LINE(W), .DEPTH(D), .RESET_PC(RPC)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_line(i_line), .i_line_valid(i_line_valid),
        .i_rd_en(i_rd_en), .i_jmp_addr(i_jmp_addr), .i_jmp_valid(i_jmp_valid),
        .o_fetch_pc(o_fetch_pc), .o_fetch_req(o_fetch_req), .o_abort(o_abort),
        .o_pc(o_pc), .o_instr(o_instr), .o_empty(o_empty), .o_full(o_full)
    );

    // Model: stored lines as a queue; word offset is implied by the PC.
    logic [32*W-1:0] m_q[$];
    logic [31:0]     m_pc = RPC;
    logic [31:0]     m_fpc = RPC & ~(LB - 32'd1);
    bit              m_wait = 1'b0;
    bit              m_abort = 1'b0;
    int              errors = 0;
    int              checks = 0;
    bit              chk_en = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [32*W-1:0] line_of(input logic [31:0] fa);
        logic [32*W-1:0] l;
        for (int k = 0; k < W; k++) l[32*k +: 32] = word_of(fa + 32'(4*k));
        return l;
    endfunction

    function automatic int m_wo();
        return int'(m_pc[31:2]) % W;
    endfunction

    function automatic bit m_bypass();
`ifdef IFQ_BYPASS_EN
        return m_wait && i_line_valid && !i_jmp_valid && (m_q.size() == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_empty();
        return (m_q.size() == 0) && !m_bypass();
    endfunction

    function automatic bit m_req();
        return !m_wait && (m_q.size() < D) && !i_jmp_valid && !i_rst;
    endfunction

    function automatic logic [31:0] m_instr();
        logic [32*W-1:0] l;
        if (m_empty()) return 32'h0;
        l = m_bypass() ? i_line : m_q[0];
        return l[32*m_wo() +: 32];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit byp, cons, last, arr, req;
        byp  = m_bypass();
        cons = i_rd_en && !m_empty() && !i_jmp_valid;
        last = cons && (m_wo() == W - 1);
        arr  = m_wait && i_line_valid;
        req  = m_req();
        if (i_rst) begin
            m_q.delete();
            m_pc = RPC; m_fpc = RPC & ~(LB - 32'd1); m_wait = 1'b0; m_abort = 1'b0;
        end else if (i_jmp_valid) begin
            m_abort = m_wait;
            m_q.delete();
            m_pc  = {i_jmp_addr[31:2], 2'b00};
            m_fpc = i_jmp_addr & ~(LB - 32'd1);
            m_wait = 1'b0;
        end else begin
            m_abort = 1'b0;
            if (last && !byp) void'(m_q.pop_front());
            if (arr && !(byp && last)) m_q.push_back(i_line);
            if (cons) m_pc = m_pc + 32'd4;
            if (arr) begin
                m_fpc = m_fpc + LB;
                m_wait = 1'b0;
            end else if (req) m_wait = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fetch_req", 32'(o_fetch_req), 32'(m_req()));
            chk("fetch_pc",  o_fetch_pc, m_fpc);
            chk("abort",     32'(o_abort), 32'(m_abort));
            chk("pc",        o_pc, m_pc);
            chk("empty",     32'(o_empty), 32'(m_empty()));
            chk("full",      32'(o_full), 32'(m_q.size() == D));
            chk("instr",     o_instr, m_instr());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        i_rd_en = 1'b0; i_jmp_valid = 1'b0; i_line_valid = 1'b0; i_jmp_addr = '0;
    endtask

    task automatic serve(input bit rd);
        i_rd_en = rd;
        i_line_valid = m_wait;
        i_line = line_of(m_fpc);
    endtask

    task automatic do_reset();
        quiet();
        i_rst = 1'b1;
        tick(); tick();
        i_rst = 1'b0;
    endtask

    logic [31:0] got_pc[$];
    logic [31:0] got_in[$];
    logic [31:0] exp_pc [5];

    initial begin
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        quiet();
        i_rst = 1'b1;
        tick();
        chk_en = 1'b1;

        // Reset state and first request
        @(negedge clk);
        chk("rst_req",   32'(o_fetch_req), 32'h0);
        chk("rst_empty", 32'(o_empty), 32'h1);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_pc",    o_pc, 32'h0);
        chk("rst_full",  32'(o_full), 32'h0);
        tick();
        i_rst = 1'b0;
        @(negedge clk);
        chk("rel_req", 32'(o_fetch_req), 32'h1);
        chk("rel_fpc", o_fetch_pc, 32'h0);
        for (int c = 0; c < 24; c++) begin
            serve(1'b1);
            @(negedge clk);
            if (!o_empty) begin
                got_pc.push_back(o_pc);
                got_in.push_back(o_instr);
            end
            tick();
        end
        chk("seq_len", 32'(got_pc.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
            chk("seq_pc", got_pc[i], exp_pc[i]);
            chk("seq_instr", got_in[i], exp_pc[i] ^ 32'hC0DE_0000);
        end

        // Fill to full, then pop one line
        do_reset();
        for (int c = 0; c < 10; c++) begin serve(1'b0); tick(); end
        quiet();
        @(negedge clk);
        chk("full_flag", 32'(o_full), 32'h1);
        chk("full_req",  32'(o_fetch_req), 32'h0);
        chk("full_fpc",  o_fetch_pc, 32'h40);
        tick();
        for (int c = 0; c < 4; c++) begin i_rd_en = 1'b1; tick(); end
        quiet();
        @(negedge clk);
        chk("pop_req",   32'(o_fetch_req), 32'h1);
        chk("pop_full",  32'(o_full), 32'h0);
        chk("pop_pc",    o_pc, 32'h10);
        chk("pop_instr", o_instr, 32'hC0DE_0010);
        tick();

        // Jump while waiting
        do_reset();
        tick();
        i_jmp_valid = 1'b1; i_jmp_addr = 32'h1238;
        @(negedge clk);
        chk("jw_req_in_jmp", 32'(o_fetch_req), 32'h0);
        tick();
        quiet();
        @(negedge clk);
        chk("jw_abort", 32'(o_abort), 32'h1);
        chk("jw_empty", 32'(o_empty), 32'h1);
        chk("jw_fpc",   o_fetch_pc, 32'h1230);
        chk("jw_pc",    o_pc, 32'h1238);
        tick();
        serve(1'b0);
        tick();
        quiet();
        @(negedge clk);
        chk("jw_tgt_pc",    o_pc, 32'h1238);
        chk("jw_tgt_instr", o_instr, 32'hC0DE_1238);
        chk("jw_abort_end", 32'(o_abort), 32'h0);
        tick();

        // Jump coinciding with line return and read
        do_reset();
        tick();
        serve(1'b0); tick();
        quiet(); tick();
        serve(1'b1);
        i_jmp_valid = 1'b1; i_jmp_addr = 32'h2005;
        tick();
        quiet();
        @(negedge clk);
        chk("jl_empty", 32'(o_empty), 32'h1);
        chk("jl_pc",    o_pc, 32'h2004);
        chk("jl_abort", 32'(o_abort), 32'h1);
        chk("jl_fpc",   o_fetch_pc, 32'h2000);
        tick();
        serve(1'b0); tick();
        quiet();
        @(negedge clk);
        chk("jl_tgt_pc",    o_pc, 32'h2004);
        chk("jl_tgt_instr", o_instr, 32'hC0DE_2004);
        tick();

        // Arrival into an empty queue
        do_reset();
        tick();
        serve(1'b0);
        @(negedge clk);
`ifdef IFQ_BYPASS_EN
        chk("byp_empty", 32'(o_empty), 32'h0);
        chk("byp_instr", o_instr, 32'hC0DE_0000);
`else
        chk("byp_empty", 32'(o_empty), 32'h1);
        chk("byp_instr", o_instr, 32'h0);
`endif
        tick();
        quiet();
        @(negedge clk);
        chk("arr_empty", 32'(o_empty), 32'h0);
        chk("arr_instr", o_instr, 32'hC0DE_0000);
        tick();

        // Reset while waiting with two lines stored
        do_reset();
        tick();
        serve(1'b0); tick();
        quiet(); i_rd_en = 1'b1; tick();
        serve(1'b1); tick();
        quiet(); tick();
        @(negedge clk);
        chk("rw_pc_before", o_pc, 32'h8);
        i_rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rw_pc",    o_pc, RPC);
        chk("rw_empty", 32'(o_empty), 32'h1);
        chk("rw_abort", 32'(o_abort), 32'h0);
        chk("rw_req",   32'(o_fetch_req), 32'h0);
        tick();
        i_rst = 1'b0;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            quiet();
            if ($urandom_range(299) == 0) begin
                i_rst = 1'b1;
            end else begin
                i_rst = 1'b0;
                i_rd_en = ($urandom_range(99) < 65);
                if (m_wait) begin
                    i_line_valid = ($urandom_range(99) < 60);
                    i_line = line_of(m_fpc);
                end else begin
                    i_line_valid = ($urandom_range(19) == 0);
                    i_line = {W{$urandom()}};
                end
                if ($urandom_range(39) == 0) begin
                    i_jmp_valid = 1'b1;
                    i_jmp_addr = $urandom() & 32'h0003_FFFF;
                end
            end
            tick();
        end
        i_rst = 1'b0;
        quiet();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifq_param.md
# ifq_param

Parametrised instruction fetch queue between the I-cache line interface and the dispatcher. It issues line-aligned fetch requests and buffers returned cache lines of WORDS_PER_LINE instructions in a DEPTH-line circular queue. It presents one instruction per cycle with its PC. It redirects on jump/branch by flushing the queue and aborting any outstanding cache request.

## Interface
- WORDS_PER_LINE, 4, 32-bit instructions per cache line; power of two, 2..16
- DEPTH, 4, queue capacity in lines; power of two, 2..16
- RESET_PC, 32'h0000_0000, PC after reset; word-aligned
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_line  in  32*WORDS_PER_LINE  returned cache line; word k at bits [32k+31:32k]
- i_line_valid  in  1  i_line valid this cycle
- i_rd_en  in  1  dispatcher consumes o_instr this cycle
- i_jmp_addr  in  32  redirect target
- i_jmp_valid  in  1  redirect request, single-cycle
- o_fetch_pc  out  32  line-aligned fetch address
- o_fetch_req  out  1  fetch request pulse, accepted by cache the same cycle
- o_abort  out  1  cancel outstanding cache request, one-cycle pulse
- o_pc  out  32  PC of o_instr
- o_instr  out  32  current instruction
- o_empty  out  1  no instruction available
- o_full  out  1  DEPTH lines stored

## Operation
- Storage: DEPTH x (32*WORDS_PER_LINE) array, line write pointer wp, line read pointer rp, word offset wo (log2 WORDS_PER_LINE bits), line count cnt (0..DEPTH).
- Fetch FSM, two states:
  - IDLE: o_fetch_req = (cnt < DEPTH) & !i_jmp_valid. On request, go to WAIT.
  - WAIT: o_fetch_req = 0. i_line_valid writes the line at wp, increments wp, and adds 4*WORDS_PER_LINE to o_fetch_pc; then go to IDLE.
  - i_line_valid in IDLE is ignored.
- Dispatch:
  - o_instr = word wo of line rp; o_pc tracks it.
  - i_rd_en & !o_empty: o_pc += 4 and wo += 1. When wo wraps from WORDS_PER_LINE-1 to 0, pop the line: rp += 1, cnt -= 1.
  - i_rd_en while o_empty has no effect.
- Redirect on i_jmp_valid, which has priority over all other events in that cycle:
  - cnt, wp and rp go to 0.
  - o_pc = i_jmp_addr & ~3.
  - o_fetch_pc = i_jmp_addr with the low log2(4*WORDS_PER_LINE) bits cleared.
  - wo = i_jmp_addr[log2(WORDS_PER_LINE)+1:2].
  - FSM goes to IDLE.
  - If the FSM was in WAIT, o_abort pulses the next cycle, and a line arriving in the jump cycle is discarded.
  - The cache drops the aborted request and returns no line for it.
- Simultaneous line write and line pop: cnt unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. o_full = (cnt == DEPTH); o_empty = (cnt == 0), except where the bypass path applies.
- o_instr = 32'h0 whenever o_empty = 1.
- i_jmp_addr[1:0] is ignored.

## Timing
- Reset values: o_pc = RESET_PC; o_fetch_pc = RESET_PC line-aligned; wo = RESET_PC word index; cnt = 0; state IDLE; o_empty = 1; o_full = 0; o_abort = 0; o_instr = 0.
- o_fetch_req is held 0 during reset and rises the first cycle after i_rst deasserts.
- Fetch-to-queue latency: a line arriving at edge N is visible on o_instr after edge N (registered write).
- Redirect: first target instruction is available one line return after o_fetch_req, which is asserted in the cycle after the jump.
- Reset mid-operation: all state returns to reset values in one cycle and no abort is issued.
- o_abort is the only registered output pulse; o_fetch_req, o_instr, o_empty and o_full are combinational from state.

## Configuration
- IFQ_BYPASS_EN defined:
  - When cnt == 0 and i_line_valid in WAIT, o_empty = 0 and o_instr/o_pc come combinationally from word wo of i_line.
  - If i_rd_en is asserted that cycle, wo advances as usual.
  - The line is still written. If wo wraps in that cycle (last word consumed), the line is not written and cnt stays 0.
- Undefined: no bypass; o_empty is strictly (cnt == 0) and arrival-to-dispatch latency is one cycle.

## Test plan
- Reset, WORDS_PER_LINE=4: o_fetch_req=1 with o_fetch_pc=0x0 one cycle after release. Return lines 0x00..0x0F with i_rd_en=1 -> o_pc runs 0x0,0x4,0x8,0xC,0x10, with matching words in order.
- Hold i_rd_en=0 and return 4 lines -> o_full=1 and o_fetch_req=0 with o_fetch_pc=0x40. One line popped (4 reads) -> o_fetch_req=1 again and cnt=3.
- i_jmp_valid with i_jmp_addr=0x1238 while in WAIT -> o_abort=1 next cycle, o_empty=1, o_fetch_pc=0x1230. Return line -> o_pc=0x1238 with word index 2 first.
- Jump in the same cycle as i_line_valid and i_rd_en -> line discarded, o_pc=target, cnt=0, no wo advance.
- With IFQ_BYPASS_EN, empty queue, line return -> o_empty=0 and o_instr = i_line word wo in the same cycle. Without the macro -> o_empty=1 in that cycle and the instruction appears next cycle.
- Assert i_rst during WAIT with cnt=2 -> next cycle o_pc=RESET_PC, cnt=0, o_abort=0, o_fetch_req=0.
